// File: rtl/result_receiver_pkg.sv
// Shared definitions for the accelerator result receiver: default word width
// and the width helper for the occupancy counter.
package result_receiver_pkg;

    localparam int RESULT_W = 21;

    // Bits needed to hold an occupancy of 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/result_ram.sv
// DEPTH x DATA_W result storage: synchronous write, asynchronous read.
// Contents are deliberately not reset; the pointers make stale words unreachable.
module result_ram
    import result_receiver_pkg::*;
#(
    parameter int DATA_W = RESULT_W,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Store the incoming word on an accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/result_receiver.sv
// Result receiver FIFO: buffers accelerator result words and hands them to the
// consumer one registered word per accepted read, with a sticky drop flag.
module result_receiver
    import result_receiver_pkg::*;
#(
    parameter int DATA_W = RESULT_W,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wrReq,
    input  logic [DATA_W-1:0]         wrData,
    input  logic                      rdReq,
    output logic [DATA_W-1:0]         rdData,
    output logic                      rdValid,
    output logic                      empty,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    input  logic                      clrOvf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              overflow_r;

    logic              empty_s;
    logic              full_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              drop_s;
    logic              ram_we_s;
    logic [DATA_W-1:0] ram_word_s;
    logic [CNT_W-1:0]  count_nxt_s;

    assign empty_s = (count_r == CNT_W'(0));
    assign full_s  = (count_r == CNT_W'(DEPTH));

    // Accept/drop decisions and next occupancy; a read frees the slot a full-cycle write needs
    always_comb begin
        rd_acc_s    = 1'b0;
        wr_acc_s    = 1'b0;
        drop_s      = 1'b0;
        count_nxt_s = count_r;
        rd_acc_s    = rdReq & ~empty_s;
        wr_acc_s    = wrReq & (~full_s | rd_acc_s);
        drop_s      = wrReq & ~wr_acc_s;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Keep storage untouched while reset is held
    assign ram_we_s = wr_acc_s & rst;

    result_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_ptr_r),
        .wdata (wrData),
        .raddr (rd_ptr_r),
        .rdata (ram_word_s)
    );

    // Pointer, occupancy, read-out and overflow state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
                rd_data_r <= ram_word_s;
            end
            rd_valid_r <= rd_acc_s;
            count_r    <= count_nxt_s;
            // A drop in the same cycle as a clear keeps the flag set
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clrOvf) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign rdData   = rd_data_r;
    assign rdValid  = rd_valid_r;
    assign empty    = empty_s;
    assign full     = full_s;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_result_receiver.sv
// Self-checking bench for result_receiver: directed scenarios plus random
// traffic, checked against a queue-based FIFO model.
module tb_result_receiver;

    localparam int DW    = 21;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wrReq;
    logic [DW-1:0] wrData;
    logic          rdReq;
    logic [DW-1:0] rdData;
    logic          rdValid;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          clrOvf;

    int vectors = 0;
    int errs    = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rd  = '0;
    logic          exp_rv  = 1'b0;
    logic          exp_ovf = 1'b0;

    result_receiver #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wrReq    (wrReq),
        .wrData   (wrData),
        .rdReq    (rdReq),
        .rdData   (rdData),
        .rdValid  (rdValid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .clrOvf   (clrOvf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rdValid"},  32'(rdValid),  32'(exp_rv));
        chk({tag, "_rdData"},   32'(rdData),   32'(exp_rd));
        chk({tag, "_count"},    32'(count),    32'(q.size()));
        chk({tag, "_empty"},    32'(empty),    32'(q.size() == 0));
        chk({tag, "_full"},     32'(full),     32'(q.size() == DEPTH));
        chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // One clock cycle of stimulus, then model update and checks
    task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d,
                         input logic r, input logic c);
        bit rd_ok;
        bit wr_ok;
        wrReq = w; wrData = d; rdReq = r; clrOvf = c;
        @(posedge clk);
        rd_ok  = r && (q.size() > 0);
        wr_ok  = w && ((q.size() < DEPTH) || rd_ok);
        exp_rv = rd_ok;
        if (rd_ok) exp_rd = q.pop_front();
        if (wr_ok) q.push_back(d);
        if (w && !wr_ok) exp_ovf = 1'b1;
        else if (c) exp_ovf = 1'b0;
        #1;
        check_all(tag);
        wrReq = 1'b0; rdReq = 1'b0; clrOvf = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wrReq = 1'b0; wrData = '0; rdReq = 1'b0; clrOvf = 1'b0;
        #3;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Three boundary words in, three out
        cycle("w0", 1'b1, 21'h00001, 1'b0, 1'b0);
        cycle("w1", 1'b1, 21'h1FFFFF, 1'b0, 1'b0);
        cycle("w2", 1'b1, 21'h0ABCD, 1'b0, 1'b0);
        cycle("r0", 1'b0, '0, 1'b1, 1'b0);
        chk("r0_const", 32'(rdData), 32'h00001);
        cycle("r1", 1'b0, '0, 1'b1, 1'b0);
        chk("r1_const", 32'(rdData), 32'h1FFFFF);
        cycle("r2", 1'b0, '0, 1'b1, 1'b0);
        chk("r2_const", 32'(rdData), 32'h0ABCD);
        cycle("idle", 1'b0, '0, 1'b0, 1'b0);
        cycle("rd_empty", 1'b0, '0, 1'b1, 1'b0);

        // Fill, drop a ninth word, clear the flag
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, DW'($urandom), 1'b0, 1'b0);
        cycle("drop", 1'b1, 21'h155555, 1'b0, 1'b0);
        cycle("drop_clr", 1'b1, 21'h0AAAAA, 1'b0, 1'b1);
        cycle("clr", 1'b0, '0, 1'b0, 1'b1);

        // Full with simultaneous read and write
        cycle("full_rw", 1'b1, 21'h123456, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
        chk("full_rw_8th", 32'(rdData), 32'h123456);

        // Empty with simultaneous read and write: no bypass
        cycle("empty_rw", 1'b1, 21'h0F0F0F, 1'b1, 1'b0);
        cycle("empty_rw_rd", 1'b0, '0, 1'b1, 1'b0);

        // Interleaved traffic across the pointer wrap
        for (int i = 0; i < 20; i++) cycle("ilv", 1'b1, DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 60; i++)
            cycle("rand", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0));
        while (q.size() > 0) cycle("flush", 1'b0, '0, 1'b1, 1'b0);

        // Build count=5 with overflow set and rdValid high, then reset asynchronously
        for (int i = 0; i < DEPTH + 1; i++) cycle("prefill", 1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("pre_rd", 1'b0, '0, 1'b1, 1'b0);
        #2;
        wrReq = 1'b1; wrData = 21'h0DEAD; rdReq = 1'b1;
        rst = 1'b0;
        q.delete(); exp_rd = '0; exp_rv = 1'b0; exp_ovf = 1'b0;
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b1; wrReq = 1'b0; rdReq = 1'b0;
        cycle("post_rst_w", 1'b1, 21'h00777, 1'b0, 1'b0);
        cycle("post_rst_r", 1'b0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
